// File: rtl/sys_data_setup_pkg.sv
// Shared types and constants for the systolic array data-setup path.
// DATA_W_DEF is the element width shared with the PE datain port.
package sys_data_setup_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_e;

    localparam int DATA_W_DEF = 8;

    // Low bit index of lane 'lane' inside a packed vector of 'width'-bit lanes.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/sys_skew_lane.sv
// One skew lane: a DEPTH-stage shift chain carrying an element and its active bit.
// Define SYS_SETUP_ZERO_GATE_EN to load zero data into bubble slots.
module sys_skew_lane #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_active,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_active,
    output logic [DATA_W-1:0] out_data
);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  active_q;
    logic [DEPTH-1:0]  active_d;

    always_comb begin
        active_d[0] = in_active;
`ifdef SYS_SETUP_ZERO_GATE_EN
        data_d[0] = in_active ? in_data : '0;
`else
        // Holding stage 0 during bubbles avoids toggling the whole chain.
        data_d[0] = in_active ? in_data : data_q[0];
`endif
        for (int i = 1; i < DEPTH; i++) begin
            active_d[i] = active_q[i-1];
            data_d[i]   = data_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            active_q <= active_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_active = active_q[DEPTH-1];
    assign out_data   = data_q[DEPTH-1];

endmodule

// File: rtl/sys_data_setup.sv
// Feeds the PE array's left column with diagonally skewed activation vectors.
// Optional macro SYS_SETUP_ZERO_GATE_EN: bubble slots carry zero data.
module sys_data_setup
    import sys_data_setup_pkg::*;
#(
    parameter int ROWS   = 8,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROWS*DATA_W-1:0] in_vec,
    input  logic                   in_last,
    output logic [ROWS*DATA_W-1:0] row_data,
    output logic [ROWS-1:0]        row_active,
    output logic                   done
);

    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              in_ready_q, in_ready_d;
    logic              accept;

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    if (in_last) begin
                        state_d = DRAIN;
                        cnt_d   = CNT_W'(ROWS - 1);
                        // A single row is fully issued on the acceptance edge itself.
                        if (ROWS == 1) begin
                            done_d = 1'b1;
                        end
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (ROWS > 1) begin
                        done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        in_ready_d = (state_d != DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;
    assign done     = done_q;

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        sys_skew_lane #(
            .DEPTH  (r + 1),
            .DATA_W (DATA_W)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_active  (accept),
            .in_data    (in_vec[lane_lo(r, DATA_W) +: DATA_W]),
            .out_active (row_active[r]),
            .out_data   (row_data[lane_lo(r, DATA_W) +: DATA_W])
        );
    end

endmodule
